// File: rtl/wave_meter.sv
// Period and peak-to-peak amplitude meter for an offset-binary sampled waveform.
// Optional macro WAVE_METER_AVG_EN averages the period over the last four periods.
module wave_meter #(
  parameter int INPUT_WIDTH = 8,
  parameter int HYST        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_valid,
  input  logic [INPUT_WIDTH-1:0] sample_in,
  output logic [15:0]            period_out,
  output logic [INPUT_WIDTH-1:0] amp_out,
  output logic                   result_valid,
  output logic                   locked,
  output logic                   timeout
);

  localparam int MID = 1 << (INPUT_WIDTH - 1);
  localparam logic [INPUT_WIDTH-1:0] LOW_TH  = INPUT_WIDTH'(MID - HYST);
  localparam logic [INPUT_WIDTH-1:0] HIGH_TH = INPUT_WIDTH'(MID + HYST);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                 state;
  logic                   low_seen;
  logic [15:0]            cnt;
  logic [INPUT_WIDTH-1:0] min_r;
  logic [INPUT_WIDTH-1:0] max_r;

  logic                   is_low;
  logic                   rising;
  logic [INPUT_WIDTH-1:0] max_n;
  logic [INPUT_WIDTH-1:0] min_n;
  logic [15:0]            period_new;
  logic [INPUT_WIDTH-1:0] amp_new;

`ifdef WAVE_METER_AVG_EN
  logic [15:0] hist0;
  logic [15:0] hist1;
  logic [15:0] hist2;
  logic [2:0]  hist_cnt;
  logic [17:0] hist_sum;
`endif

  // Crossing detection and the extremes including the current sample.
  always_comb begin
    is_low     = sample_valid && (sample_in < LOW_TH);
    rising     = sample_valid && low_seen && (sample_in >= HIGH_TH);
    max_n      = (sample_in > max_r) ? sample_in : max_r;
    min_n      = (sample_in < min_r) ? sample_in : min_r;
    period_new = cnt + 16'd1;
    amp_new    = max_n - min_n;
`ifdef WAVE_METER_AVG_EN
    hist_sum   = {2'b00, period_new} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};
`endif
  end

  // Measurement state machine; invalid cycles leave everything but the pulses untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      low_seen     <= 1'b0;
      cnt          <= 16'd0;
      min_r        <= '0;
      max_r        <= '0;
      period_out   <= 16'd0;
      amp_out      <= '0;
      result_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
`ifdef WAVE_METER_AVG_EN
      hist0        <= 16'd0;
      hist1        <= 16'd0;
      hist2        <= 16'd0;
      hist_cnt     <= 3'd0;
`endif
    end else begin
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      if (sample_valid) begin
        if (is_low) begin
          low_seen <= 1'b1;
        end else if (rising) begin
          low_seen <= 1'b0;
        end
        case (state)
          IDLE: begin
            if (rising) begin
              state    <= RUN;
              locked   <= 1'b1;
              cnt      <= 16'd0;
              min_r    <= sample_in;
              max_r    <= sample_in;
`ifdef WAVE_METER_AVG_EN
              hist_cnt <= 3'd0;
`endif
            end
          end
          RUN: begin
            if (rising) begin
`ifdef WAVE_METER_AVG_EN
              hist0 <= period_new;
              hist1 <= hist0;
              hist2 <= hist1;
              if (hist_cnt >= 3'd3) begin
                period_out   <= hist_sum[17:2];
                amp_out      <= amp_new;
                result_valid <= 1'b1;
                hist_cnt     <= 3'd4;
              end else begin
                hist_cnt <= hist_cnt + 3'd1;
              end
`else
              period_out   <= period_new;
              amp_out      <= amp_new;
              result_valid <= 1'b1;
`endif
              cnt   <= 16'd0;
              min_r <= sample_in;
              max_r <= sample_in;
            end else if (cnt == 16'hFFFF) begin
              // Loss of signal: drop lock but keep the last reported result.
              state    <= IDLE;
              locked   <= 1'b0;
              timeout  <= 1'b1;
              cnt      <= 16'd0;
`ifdef WAVE_METER_AVG_EN
              hist_cnt <= 3'd0;
              hist0    <= 16'd0;
              hist1    <= 16'd0;
              hist2    <= 16'd0;
`endif
            end else begin
              cnt   <= cnt + 16'd1;
              min_r <= min_n;
              max_r <= max_n;
            end
          end
          default: begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_meter.sv
// Randomized scoreboard bench for wave_meter (default build) against a sample-history reference model.
module tb_wave_meter;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_valid;
  logic [7:0]  sample_in;
  logic [15:0] period_out;
  logic [7:0]  amp_out;
  logic        result_valid;
  logic        locked;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  // Reference model state: every sample since the last rising event, kept whole.
  bit       m_low_seen = 1'b0;
  bit       m_locked   = 1'b0;
  int       m_hist[$];
  int       exp_period_q[$];
  int       exp_amp_q[$];
  int       exp_to = 0;

  wave_meter #(.INPUT_WIDTH(8), .HYST(4)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .period_out(period_out), .amp_out(amp_out), .result_valid(result_valid),
    .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a rising event closes a period spanning the stored samples.
  task automatic model_step(input int v);
    bit ev;
    int mn, mx;
    ev = m_low_seen && (v >= 132);
    if (v < 124) m_low_seen = 1'b1;
    else if (ev) m_low_seen = 1'b0;
    if (!m_locked) begin
      if (ev) begin
        m_locked = 1'b1;
        m_hist.delete();
        m_hist.push_back(v);
      end
    end else if (ev) begin
      mn = v; mx = v;
      foreach (m_hist[i]) begin
        if (m_hist[i] < mn) mn = m_hist[i];
        if (m_hist[i] > mx) mx = m_hist[i];
      end
      exp_period_q.push_back(m_hist.size());
      exp_amp_q.push_back(mx - mn);
      m_hist.delete();
      m_hist.push_back(v);
    end else if (m_hist.size() == 65536) begin
      m_locked = 1'b0;
      exp_to++;
      m_hist.delete();
    end else begin
      m_hist.push_back(v);
    end
  endtask

  task automatic drive(input bit valid, input int v);
    @(posedge clk);
    #2;
    check("locked", {31'd0, locked}, {31'd0, m_locked});
    sample_valid = valid;
    sample_in    = v[7:0];
    if (valid) model_step(v);
  endtask

  task automatic do_reset(input bit with_valid);
    @(posedge clk);
    #2;
    reset        = 1'b1;
    sample_valid = with_valid;
    sample_in    = 8'hF0;
    @(posedge clk);
    #1;
    m_low_seen = 1'b0;
    m_locked   = 1'b0;
    m_hist.delete();
    exp_period_q.delete();
    exp_amp_q.delete();
    exp_to = 0;
    check("rst_period", {16'd0, period_out}, 32'd0);
    check("rst_amp", {24'd0, amp_out}, 32'd0);
    check("rst_valid", {31'd0, result_valid}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    reset        = 1'b0;
    sample_valid = 1'b0;
  endtask

  // Square wave, gap_mode 0: always valid, 1: valid one cycle in three, 2: random gaps.
  task automatic square(input int nsamp, input int gap_mode);
    int k;
    k = 0;
    for (int i = 0; i < nsamp; i++) begin
      if (gap_mode == 1) begin drive(1'b0, 0); drive(1'b0, 0); end
      if (gap_mode == 2) while ($urandom_range(0, 2) == 0) drive(1'b0, $urandom_range(0, 255));
      drive(1'b1, (k % 64) < 32 ? 32'h10 : 32'hF0);
      k++;
    end
  endtask

  // Monitor: pop the scoreboard whenever the DUT presents a result or timeout.
  always @(negedge clk) begin
    if (result_valid) begin
      if (exp_period_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        check("period", {16'd0, period_out}, exp_period_q.pop_front());
        check("amp", {24'd0, amp_out}, exp_amp_q.pop_front());
      end
    end
    if (timeout) begin
      if (exp_to == 0) begin
        check("unexpected_timeout", 32'd1, 32'd0);
      end else begin
        check("timeout_pulse", 32'd1, 32'd1);
        exp_to--;
      end
    end
  end

  initial begin
    int p, lo, hi, jit;
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_in    = 8'h00;
    repeat (3) @(posedge clk);
    do_reset(1'b1);

    // Continuous square wave.
    square(64 * 5 + 10, 0);
    check("sq_period", {16'd0, period_out}, 32'd64);
    check("sq_amp", {24'd0, amp_out}, 32'hE0);
    check("sq_locked", {31'd0, locked}, 32'd1);

    // Same waveform, valid one cycle in three, then random gaps.
    do_reset(1'b0);
    square(64 * 4, 1);
    check("gap_period", {16'd0, period_out}, 32'd64);
    check("gap_amp", {24'd0, amp_out}, 32'hE0);
    do_reset(1'b0);
    square(64 * 3 + 5, 2);

    // Noise inside the hysteresis band must never lock.
    do_reset(1'b0);
    for (int i = 0; i < 60; i++) drive(1'b1, (i % 2) ? 32'h82 : 32'h7E);
    check("noise_locked", {31'd0, locked}, 32'd0);

    // Random periodic waveforms with jitter and gaps.
    for (int w = 0; w < 12; w++) begin
      p   = $urandom_range(6, 120);
      lo  = $urandom_range(0, 110);
      hi  = $urandom_range(140, 250);
      jit = $urandom_range(0, 5);
      for (int c = 0; c < 3; c++)
        for (int i = 0; i < p; i++) begin
          if ($urandom_range(0, 3) == 0) drive(1'b0, $urandom_range(0, 255));
          drive(1'b1, ((i < p / 2) ? lo : hi) + $urandom_range(0, jit));
        end
    end
    for (int i = 0; i < 400; i++) drive($urandom_range(0, 1), $urandom_range(0, 255));

    // Reset 20 samples into a period with sample_valid high, then recover.
    do_reset(1'b0);
    square(64 * 2 + 20, 0);
    do_reset(1'b1);
    square(64 * 3, 0);
    check("post_rst_period", {16'd0, period_out}, 32'd64);

    // Loss of signal after lock.
    do_reset(1'b0);
    square(64 * 2 + 40, 0);
    for (int i = 0; i < 65540; i++) drive(1'b1, 32'h80);
    drive(1'b0, 0);
    drive(1'b0, 0);
    check("to_locked", {31'd0, locked}, 32'd0);
    check("to_period", {16'd0, period_out}, 32'd64);

    repeat (3) @(posedge clk);
    check("pending_results", exp_period_q.size(), 32'd0);
    check("pending_timeouts", exp_to, 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
